// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, default frame length and counter-width helper for the SPI frame reader.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} spi_state_t;

    localparam int SPI_FRAME_BITS_DEF = 24;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_frame_reader_if.sv
// spi_frame_reader_if: sensor-side SPI pins plus the parallel frame handshake.
interface spi_frame_reader_if
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS_DEF
);
    logic start;
    logic miso;
    logic sclk;
    logic cs_n;
    logic busy;
    logic new_data;
    logic [FRAME_BITS-1:0] data;

    modport master (input start, miso, output sclk, cs_n, busy, data, new_data);
    modport slave (output start, miso, input sclk, cs_n, busy, data, new_data);
endinterface

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: one-cycle tick every CLK_DIV clocks, restarted by clr.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV) + 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = cnt_q == W'(CLK_DIV - 1);
        cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/spi_frame_reader.sv
// spi_frame_reader: SPI mode-0 read-only master returning one FRAME_BITS word per frame.
// Define SPI_AUTO_POLL_EN to add a free-running poll counter that starts a frame every POLL_CYCLES.
module spi_frame_reader
    import spi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BITS  = SPI_FRAME_BITS_DEF,
    parameter int POLL_CYCLES = 1000000
) (
    input logic clk,
    input logic rst,
    spi_frame_reader_if.master bus
);
    localparam int BW = cnt_w(FRAME_BITS + 1);

    spi_state_t state_q, state_d;
    logic sclk_q, sclk_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic tick, go, rise, fall, last_bit;

`ifdef SPI_AUTO_POLL_EN
    localparam int PW = cnt_w(POLL_CYCLES);

    logic [PW-1:0] poll_q, poll_d;
    logic poll_wrap;

    always_comb begin
        poll_wrap = poll_q == PW'(POLL_CYCLES - 1);
        poll_d = poll_wrap ? '0 : poll_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        poll_q <= rst ? '0 : poll_d;
    end

    // a wrap while a frame is running is simply lost, never deferred
    assign go = bus.start | poll_wrap;
`else
    if (CLK_DIV < 1 || POLL_CYCLES < 1) begin : g_cfg_guard
    end

    assign go = bus.start;
`endif

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .tick(tick)
    );

    // every sclk rising edge doubles as the miso sample point
    always_comb begin
        last_bit = bit_q == BW'(FRAME_BITS);
        rise = tick && (state_q == SETUP || (state_q == SHIFT && !sclk_q && !last_bit));
        fall = tick && state_q == SHIFT && sclk_q;
        sclk_d = rise ? 1'b1 : fall ? 1'b0 : sclk_q;
        shift_d = rise ? (shift_q << 1) | FRAME_BITS'(bus.miso) : shift_q;
        bit_d = (state_q == IDLE) ? '0 : bit_q + BW'(rise);
        data_d = (state_q == HOLD && tick) ? shift_q : data_q;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? SETUP : IDLE;
            SETUP:   state_d = tick ? SHIFT : SETUP;
            SHIFT:   state_d = (tick && !sclk_q && last_bit) ? HOLD : SHIFT;
            HOLD:    state_d = tick ? DONE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.cs_n     = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
    assign bus.busy     = state_q != IDLE;
    assign bus.new_data = state_q == DONE;
    assign bus.data     = data_q;
endmodule

// File: tb/tb_spi_frame_reader.sv
// tb_spi_frame_reader: random-word frames on CLK_DIV=4 and CLK_DIV=1 readers against a shifting sensor model.
module tb_spi_frame_reader;
    localparam int FB = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [FB-1:0] w0 = '0;
    logic [FB-1:0] w1 = '0;
    int i0 = 0, i1 = 0;
    int lo0 = 0, lo1 = 0, rise0 = 0, rise1 = 0;
    int nd0 = 0, nd1 = 0, ndc0 = 0, ndc1 = 0;
    int hi1 = 0, gap1 = 0;
    logic sp0 = 1'b0, sp1 = 1'b0;

    spi_frame_reader_if #(.FRAME_BITS(FB)) b0 ();
    spi_frame_reader_if #(.FRAME_BITS(FB)) b1 ();

    spi_frame_reader #(.CLK_DIV(4), .FRAME_BITS(FB), .POLL_CYCLES(1000000)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    spi_frame_reader #(.CLK_DIV(1), .FRAME_BITS(FB), .POLL_CYCLES(1000000)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // sensor: presents the MSB when selected and moves to the next bit on each sclk fall
    always @(negedge b0.sclk or posedge b0.cs_n) i0 <= b0.cs_n ? 0 : i0 + 1;
    always @(negedge b1.sclk or posedge b1.cs_n) i1 <= b1.cs_n ? 0 : i1 + 1;
    assign b0.miso = (i0 < FB) ? w0[FB-1-i0] : 1'b0;
    assign b1.miso = (i1 < FB) ? w1[FB-1-i1] : 1'b0;

    always @(negedge clk) begin
        lo0   <= lo0 + int'(!b0.cs_n);
        lo1   <= lo1 + int'(!b1.cs_n);
        sp0   <= b0.sclk;
        sp1   <= b1.sclk;
        rise0 <= rise0 + int'(b0.sclk && !sp0);
        rise1 <= rise1 + int'(b1.sclk && !sp1);
        hi1   <= b1.cs_n ? hi1 + 1 : 0;
        if (!b1.cs_n && hi1 != 0) gap1 <= hi1;
        if (b0.new_data) begin
            nd0  <= nd0 + 1;
            ndc0 <= cyc;
        end
        if (b1.new_data) begin
            nd1  <= nd1 + 1;
            ndc1 <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one frame on reader sel; x>0 re-pulses start at x and 2x cycles into the frame
    task automatic frame(input bit sel, input logic [FB-1:0] w, input int x);
        int d, s, nb, lb, rb;
        bit seen, st;
        d = sel ? 1 : 4;
        if (sel) w1 = w; else w0 = w;
        nb = sel ? nd1 : nd0;
        lb = sel ? lo1 : lo0;
        rb = sel ? rise1 : rise0;
        s = cyc;
        seen = 1'b0;
        for (int i = 0; i < (2 * FB + 2) * d + 40 && !seen; i++) begin
            st = (i == 0) || (x != 0 && (i == x || i == 2 * x));
            if (sel) b1.start = st; else b0.start = st;
            @(negedge clk);
            #1;
            seen = (sel ? nd1 : nd0) != nb;
        end
        b0.start = 1'b0;
        b1.start = 1'b0;
        check(sel ? "timeout1" : "timeout0", 64'(seen), 64'd1);
        check(sel ? "latency1" : "latency0", 64'((sel ? ndc1 : ndc0) - s), 64'((2 * FB + 2) * d + 1));
        check(sel ? "data1" : "data0", 64'(sel ? b1.data : b0.data), 64'(w));
        check(sel ? "cs_low1" : "cs_low0", 64'((sel ? lo1 : lo0) - lb), 64'((2 * FB + 2) * d));
        check(sel ? "sclk_rises1" : "sclk_rises0", 64'((sel ? rise1 : rise0) - rb), 64'(FB));
        repeat (4) @(negedge clk);
        #1;
        check(sel ? "pulses1" : "pulses0", 64'((sel ? nd1 : nd0) - nb), 64'd1);
        check(sel ? "idle_busy1" : "idle_busy0", 64'(sel ? b1.busy : b0.busy), 64'd0);
        check(sel ? "idle_cs1" : "idle_cs0", 64'(sel ? b1.cs_n : b0.cs_n), 64'd1);
    endtask

    task automatic mid_reset();
        int nb;
        w0 = FB'($urandom);
        nb = nd0;
        for (int i = 0; i < 71; i++) begin
            b0.start = (i == 0);
            rst = (i == 70);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        check("rst_sclk", 64'(b0.sclk), 64'd0);
        check("rst_cs_n", 64'(b0.cs_n), 64'd1);
        check("rst_busy", 64'(b0.busy), 64'd0);
        check("rst_data", 64'(b0.data), 64'd0);
        repeat (250) @(negedge clk);
        #1;
        check("rst_no_pulse", 64'(nd0 - nb), 64'd0);
    endtask

    task automatic back_to_back();
        logic [FB-1:0] q [3];
        int nb;
        for (int f = 0; f < 3; f++) q[f] = FB'($urandom);
        w1 = q[0];
        b1.start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            nb = nd1;
            for (int i = 0; i < 80 && nd1 == nb; i++) begin
                @(negedge clk);
                #1;
            end
            check("b2b_pulse", 64'(nd1 - nb), 64'd1);
            check("b2b_data", 64'(b1.data), 64'(q[f]));
            if (f > 0) check("b2b_gap", 64'(gap1), 64'd2);
            if (f < 2) w1 = q[f+1];
        end
        b1.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("b2b_stop", 64'(b1.cs_n), 64'd1);
    endtask

    initial begin
        b0.start = 1'b0;
        b1.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_sclk", 64'({b0.sclk, b1.sclk}), 64'd0);
        check("reset_cs_n", 64'({b0.cs_n, b1.cs_n}), 64'd3);
        check("reset_busy", 64'({b0.busy, b1.busy}), 64'd0);
        check("reset_data", 64'({b0.data, b1.data}), 64'd0);
        check("reset_new_data", 64'({b0.new_data, b1.new_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        frame(1'b0, 24'h1A2B3C, 0);
        frame(1'b0, FB'($urandom), 40);
        frame(1'b0, FB'($urandom), 0);
        mid_reset();
        frame(1'b0, FB'($urandom), 0);
        frame(1'b1, 24'hFFFFFF, 0);
        frame(1'b1, 24'h000000, 0);
        for (int k = 0; k < 3; k++) frame(1'b1, FB'($urandom), 0);
        back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_frame_reader.md
Name: spi_frame_reader

Overview:
SPI mode-0 master that clocks one fixed-length read frame out of the temperature sensor and delivers it as a parallel word with a one-cycle valid strobe.
- Output word and strobe feed the downstream BCD display register: data drives its 24-bit frame input, new_data drives its update strobe.
- Read-only master: no MOSI; the sensor is addressed purely by chip-select.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range >=1
FRAME_BITS, 24, bits per frame, MSB first
POLL_CYCLES, 1000000, auto-poll period in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  request one frame; sampled only in IDLE
miso  in  1  serial data from sensor, pre-synchronised externally
sclk  out  1  SPI clock; idle low
cs_n  out  1  chip select, active-low
busy  out  1  frame in progress
data  out  FRAME_BITS  last completed frame
new_data  out  1  one-cycle pulse when data updates

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: sclk=0, cs_n=1, busy=0, data=0, new_data=0, state=IDLE, all counters 0.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 at edge k -> from cycle k+1: cs_n=0, busy=1, state=SETUP.
  - start while not in IDLE is ignored (no queueing).
- SETUP: lasts CLK_DIV cycles with sclk=0, then SHIFT.
- SHIFT:
  - FRAME_BITS SCLK periods; each period is CLK_DIV cycles high, then CLK_DIV cycles low.
  - miso is sampled into the shift register on the clk edge that drives sclk 0->1.
  - MSB is first: the first sample lands in bit FRAME_BITS-1.
  - After the last low half-period -> HOLD.
- HOLD: CLK_DIV cycles with sclk=0, cs_n=0.
- DONE:
  - Single cycle: cs_n=1, data <= shift register, new_data=1, busy=1.
  - Next cycle: IDLE, busy=0, new_data=0.
- Latency:
  - cs_n is low for exactly (2*FRAME_BITS+2)*CLK_DIV cycles.
  - new_data goes high in cycle k+1+(2*FRAME_BITS+2)*CLK_DIV.
  - Defaults: 200 cycles low; new_data at k+201.
- Back-to-back: start held high in the cycle after DONE begins the next frame.
  - Minimum cs_n high time is therefore 2 cycles (the DONE cycle plus the IDLE cycle).
- data holds its value between frames; it changes only in DONE.
- Reset mid-frame, on the next edge:
  - sclk=0, cs_n=1, busy=0.
  - data returns to 0; no new_data pulse.
  - Partial frame is discarded.
- Reset and start in the same cycle: reset wins.
- Counters:
  - Half-period counter width is $clog2(CLK_DIV)+1.
  - Bit counter width is $clog2(FRAME_BITS+1).
  - No wrap occurs within a legal frame.

Optional Feature:
SPI_AUTO_POLL_EN
- Defined:
  - A free-running counter counts 0..POLL_CYCLES-1 and wraps to 0.
  - At wrap it issues an internal start pulse, ORed with the start port.
  - The pulse is dropped if busy; it is not deferred.
  - The counter is cleared by rst.
- Undefined: no poll counter exists; frames start only via the start port.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_t {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - Constant SPI_FRAME_BITS_DEF=24.
  - Helper function for counter widths.
- Sub-module spi_tick_gen:
  - Counts CLK_DIV cycles and pulses a one-cycle tick.
  - Cleared whenever the FSM changes state.
  - The FSM advances on ticks.

Test Plan:
- Sensor model shifts 24'h1A2B3C on sclk falling edges, start pulsed at cycle 10 -> data=24'h1A2B3C, new_data high only in cycle 211, cs_n low cycles 11-210.
- start re-pulsed at cycles 50 and 100 during a frame -> ignored; exactly one new_data pulse; 24 sclk rising edges counted.
- rst asserted at cycle 80 mid-frame -> next cycle sclk=0, cs_n=1, busy=0, data=0; no new_data; a following start yields a clean full frame.
- CLK_DIV=1, miso all ones then all zeros -> data=24'hFFFFFF then 24'h000000; sclk period 2 cycles; new_data 51 cycles after each start.
- start held high continuously -> frames repeat; cs_n high exactly 2 cycles between frames; data updates each frame.
- SPI_AUTO_POLL_EN, POLL_CYCLES=500, start tied 0 -> new_data every 500 cycles; first poll-counter wrap at cycle 499 after reset release.
